// File: rtl/if1_fetch_queue.sv
// IF1 -> decode fetch-packet queue: circular buffer of DEPTH normalised packets.
// Define IF1_FIFO_BYPASS_EN to let a packet pass straight through an empty queue.
module if1_fetch_queue #(
   parameter int          FETCH_WIDTH = 2,
   parameter int          DEPTH       = 4,
   parameter logic [31:0] PC_RESET    = 32'h1c000000,
   parameter logic [31:0] INST_NOP    = 32'h03400000
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic                        flush,
   input  logic                        stall,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [31:0]                 in_pc,
   input  logic [32*FETCH_WIDTH-1:0]   in_inst,
   input  logic [FETCH_WIDTH-1:0]      in_mask,
   input  logic [6:0]                  in_excp,
   input  logic [31:0]                 in_badv,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [31:0]                 out_pc,
   output logic [32*FETCH_WIDTH-1:0]   out_inst,
   output logic [FETCH_WIDTH-1:0]      out_mask,
   output logic [6:0]                  out_excp,
   output logic [31:0]                 out_badv,
   output logic [$clog2(DEPTH):0]      count,
   output logic                        full,
   output logic                        empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [AW-1:0]               wr_ptr, rd_ptr;
   logic [CW-1:0]               cnt;
   logic                        push, pop, bypass;
   logic [32*FETCH_WIDTH-1:0]   norm_inst;
   logic [FETCH_WIDTH-1:0]      norm_mask;
   logic [31:0]                 norm_badv;

   logic [31:0]                 pc_mem   [DEPTH];
   logic [32*FETCH_WIDTH-1:0]   inst_mem [DEPTH];
   logic [FETCH_WIDTH-1:0]      mask_mem [DEPTH];
   logic [6:0]                  excp_mem [DEPTH];
   logic [31:0]                 badv_mem [DEPTH];

   // Exception packets carry no usable instructions: only slot 0 stays valid, all NOPs.
   always_comb begin
      norm_inst = '0;
      for (int i = 0; i < FETCH_WIDTH; i++) begin
         norm_inst[i*32 +: 32] = (in_excp == 7'd0 && in_mask[i]) ? in_inst[i*32 +: 32] : INST_NOP;
      end
      norm_mask = (in_excp != 7'd0) ? FETCH_WIDTH'(1) : in_mask;
      norm_badv = (in_excp != 7'd0) ? in_badv : 32'h0;
   end

   assign full     = (cnt == CW'(DEPTH));
   assign empty    = (cnt == '0);
   assign count    = cnt;
   assign in_ready = !full && !stall && !flush;

`ifdef IF1_FIFO_BYPASS_EN
   assign bypass = empty && in_valid && !stall && !flush && out_ready;
`else
   assign bypass = 1'b0;
`endif

   assign push = in_valid && in_ready && !bypass;
   assign pop  = !empty && out_ready;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      cnt <= cnt + 1'b1;
         else if (pop && !push) cnt <= cnt - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem[wr_ptr]   <= in_pc;
         inst_mem[wr_ptr] <= norm_inst;
         mask_mem[wr_ptr] <= norm_mask;
         excp_mem[wr_ptr] <= in_excp;
         badv_mem[wr_ptr] <= norm_badv;
      end
   end

   // Idle output shows reset values so decode never sees stale entries.
   always_comb begin
      out_valid = 1'b0;
      out_pc    = PC_RESET;
      out_inst  = {FETCH_WIDTH{INST_NOP}};
      out_mask  = '0;
      out_excp  = '0;
      out_badv  = '0;
      if (!empty) begin
         out_valid = 1'b1;
         out_pc    = pc_mem[rd_ptr];
         out_inst  = inst_mem[rd_ptr];
         out_mask  = mask_mem[rd_ptr];
         out_excp  = excp_mem[rd_ptr];
         out_badv  = badv_mem[rd_ptr];
      end else if (bypass) begin
         out_valid = 1'b1;
         out_pc    = in_pc;
         out_inst  = norm_inst;
         out_mask  = norm_mask;
         out_excp  = in_excp;
         out_badv  = norm_badv;
      end
   end

   always @(posedge clk) begin
      if (rstn && !flush) begin
         assert (!(push && full));
         assert (!(pop && empty));
      end
   end

endmodule

// File: doc/if1_fetch_queue.md
Name: if1_fetch_queue

Overview:
Parametrised fetch-packet queue between the IF1 stage (ICache read return) and decode.
- Buffers up to DEPTH packets. Each packet is one PC, FETCH_WIDTH instructions, a per-slot valid mask, and exception info.
- Uses valid/ready handshakes on both sides, with synchronous flush and stall.
- Replaces the single-register IF1 latch with real buffering, so fetch can run ahead of decode.

Parameters:
- FETCH_WIDTH, 2, instructions per packet (1..4).
- DEPTH, 4, queue entries; power of two, >= 2.
- PC_RESET, 32'h1c000000, PC value driven on out_pc when empty/reset.
- INST_NOP, 32'h03400000, instruction value driven on idle/masked slots.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- flush  in  1  synchronous flush (branch mispredict / exception redirect)
- stall  in  1  blocks enqueue when high
- in_valid  in  1  IF1 packet valid (ICache data ready)
- in_ready  out  1  queue accepts packet
- in_pc  in  32  packet PC
- in_inst  in  32*FETCH_WIDTH  instructions; slot 0 in bits [31:0]
- in_mask  in  FETCH_WIDTH  per-slot valid
- in_excp  in  7  exception code; 0 means none
- in_badv  in  32  bad virtual address for the exception
- out_valid  out  1  head packet valid
- out_ready  in  1  decode accepts head
- out_pc  out  32  head PC
- out_inst  out  32*FETCH_WIDTH  head instructions
- out_mask  out  FETCH_WIDTH  head slot mask
- out_excp  out  7  head exception code
- out_badv  out  32  head bad address
- count  out  $clog2(DEPTH)+1  occupied entries
- full  out  1  count == DEPTH
- empty  out  1  count == 0

Behaviour:
- Reset (rstn low, asynchronous):
  - Read/write pointers and count go to 0; empty=1, full=0.
  - out_valid=0, out_pc=PC_RESET, out_inst=all INST_NOP, out_mask=0, out_excp=0, out_badv=0.
- Storage: circular buffer indexed by wr_ptr/rd_ptr of width $clog2(DEPTH). Pointers wrap DEPTH-1 -> 0. count is tracked separately, so full/empty are unambiguous.
- in_ready = !full && !stall && !flush. It is registered-state only: no combinational path from out_ready.
- Push occurs when in_valid && in_ready. The packet is written at wr_ptr and wr_ptr increments.
- Pop occurs when out_valid && out_ready. rd_ptr increments.
- Push and pop in the same cycle: count unchanged. This is legal at any non-empty, non-full count.
- When full: in_ready=0, even if a pop occurs in the same cycle. The push is accepted the following cycle.
- Output side:
  - out_valid = !empty.
  - The out_* fields present the entry at rd_ptr.
  - When empty, out_* fields show the reset values.
- Latency: a packet pushed at edge N appears on out_* in the cycle after edge N (one cycle minimum).
- Exception packet (in_excp != 0):
  - Stored with out_mask forced to 1 (slot 0 only) and every instruction slot forced to INST_NOP.
  - in_badv is stored unchanged.
  - Non-exception packets store in_badv as 0.
- Masked slots (in_mask bit = 0): the stored instruction is INST_NOP.
- Flush:
  - At the next edge, the pointers and count clear to 0.
  - A push and a pop presented in the flush cycle are both discarded.
  - Flush has priority over stall, push and pop.
- Stall: affects the enqueue side only. Pops continue while stall is high.
- Overflow/underflow are impossible by construction. Any write while full, or read while empty, is a design error and is checked by assertion in simulation.

Optional Feature:
IF1_FIFO_BYPASS_EN
- When defined: if the queue is empty and in_valid && !stall && !flush && out_ready, then:
  - out_valid=1;
  - out_* are driven combinationally from in_* (after the same exception/mask normalisation);
  - the packet is consumed without being written; count stays 0 and in_ready=1.
- When the queue is empty and out_ready=0, the normal push occurs.
- When not defined: no combinational in-to-out path; the minimum latency is one cycle.

Test Plan:
- Reset, then push 4 packets (pc 0x1c000000, +8, +16, +24) with out_ready=0.
  -> count=4, full=1, in_ready=0; the 5th in_valid is held off.
- From full, assert out_ready=1 and hold in_valid.
  -> Pops return PCs in order 0x1c000000..0x1c000018. The first pop cycle accepts no push; steady state then holds count=3 with push+pop each cycle through pointer wrap.
- Push pc=0x1c000100, in_excp=7'h08, in_badv=0x1c000102, in_mask=2'b11.
  -> Head shows mask=2'b01, inst={NOP,NOP}, badv=0x1c000102.
- Fill 3 entries, then assert flush with in_valid=1 and out_ready=1 in the same cycle.
  -> Next cycle count=0, empty=1, out_pc=0x1c000000, no packet emitted.
- stall=1 with 2 entries and out_ready=1.
  -> in_ready=0; both entries drain in 2 cycles; count=0.
- With IF1_FIFO_BYPASS_EN, empty queue, in_valid=1, pc=0x1c000040, out_ready=1.
  -> out_pc=0x1c000040 in the same cycle, count stays 0.
